alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter N, default 64, operand/result width.
REQ-002 SHALL have parameter MD_CYCLES, default 4, execute cycles for mul/div/rem ops (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid (bit 0 = EXU, bit 1 = secondary).
REQ-006 SHALL have port req_ready  output  2  per-requester accept.
REQ-007 SHALL have ports req_a0, req_b0, req_a1, req_b1  input  N  operands per requester.
REQ-008 SHALL have ports req_sel0, req_sel1  input  5  ALU op select per requester.
REQ-009 SHALL have port resp_valid  output  1  result valid.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port resp_id  output  1  index of requester owning result.
REQ-012 SHALL have port resp_res  output  N  result.
REQ-013 SHALL have port busy  output  1  high when state != IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-015 In IDLE, req_ready SHALL be one-hot to the granted valid requester, combinationally; all zero outside IDLE or with no valid.
REQ-016 Handshake (req_valid[i] & req_ready[i]) SHALL latch A, B, sel, id into operand registers and enter EXEC next cycle.
REQ-017 A requester dropping req_valid before handshake SHALL be legal; nothing latched.
REQ-018 Multi-cycle class SHALL be sel in {2..6, 24..28}; EXEC lasts MD_CYCLES cycles; all other sel values last 1 cycle.
REQ-019 Cycle counter SHALL load MD_CYCLES-1 (or 0) on handshake, decrement per EXEC cycle; at 0, ALU output registered into resp_res and state -> RESP.
REQ-020 Latency SHALL be: handshake in cycle T, resp_valid high in cycle T+1+L, L = execute cycles (simple op: T+2).
REQ-021 Undefined sel (29..31) SHALL yield resp_res = 0, single-cycle class.
REQ-022 In RESP, resp_valid, resp_id, resp_res SHALL stay stable until resp_ready; handshake returns to IDLE; no new grant in that same cycle (one bubble).
REQ-023 Division/remainder by zero results SHALL be exactly those of the ALU datapath (quotient all-ones, remainder = dividend); scheduler adds no masking.
REQ-024 Operand registers SHALL not change outside the IDLE handshake.

Reset
REQ-025 On rst: state IDLE, req_ready 0, resp_valid 0, resp_id 0, resp_res 0, busy 0, counter 0, last_grant 1.
REQ-026 rst in EXEC or RESP SHALL discard the in-flight op with no response emitted.

Configuration
REQ-027 Macro ALU_SCHED_RR_EN defined: round-robin; when both valid, grant requester != last_grant; last_grant updates on each handshake.
REQ-028 Macro ALU_SCHED_RR_EN undefined: fixed priority, requester 0 always wins ties; last_grant register absent.

Structure
REQ-029 Shared package SHALL hold ALU sel encoding constants (ADD=0 .. REMUW=28), the FSM state enum, and the is-multicycle decode function.
REQ-030 SHALL instantiate exactly one sub-module, alu (parameter N), fed from operand registers.

Verification
REQ-031 Req0 ADD A=5 B=7 handshake cycle 0 -> resp_valid cycle 2, resp_res=12, resp_id=0.
REQ-032 Req1 DIVU A=100 B=0, MD_CYCLES=4 -> resp_valid cycle 5, resp_res=all-ones, resp_id=1.
REQ-033 Both valid every cycle, RR_EN defined, resp_ready=1 -> grants 0,1,0,1; undefined -> grants 0,0,0,0.
REQ-034 resp_ready held 0 for 3 cycles after resp_valid -> outputs stable, req_ready=00, busy=1; release -> IDLE next cycle.
REQ-035 rst asserted during EXEC of MUL -> next cycle resp_valid=0, busy=0; new ADD 1+1 -> resp_res=2.
REQ-036 sel=30 A=3 B=4 -> resp_res=0 at handshake+2.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: ALU op encodings, FSM states and
// the multi-cycle op decode.
package alu_sched_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_MUL    = 5'd2;
    localparam logic [4:0] ALU_MULH   = 5'd3;
    localparam logic [4:0] ALU_MULHSU = 5'd4;
    localparam logic [4:0] ALU_MULHU  = 5'd5;
    localparam logic [4:0] ALU_DIV    = 5'd6;
    localparam logic [4:0] ALU_AND    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_XOR    = 5'd9;
    localparam logic [4:0] ALU_SLL    = 5'd10;
    localparam logic [4:0] ALU_SRL    = 5'd11;
    localparam logic [4:0] ALU_SRA    = 5'd12;
    localparam logic [4:0] ALU_SLT    = 5'd13;
    localparam logic [4:0] ALU_SLTU   = 5'd14;
    localparam logic [4:0] ALU_ADDW   = 5'd15;
    localparam logic [4:0] ALU_SUBW   = 5'd16;
    localparam logic [4:0] ALU_SLLW   = 5'd17;
    localparam logic [4:0] ALU_SRLW   = 5'd18;
    localparam logic [4:0] ALU_SRAW   = 5'd19;
    localparam logic [4:0] ALU_SEQ    = 5'd20;
    localparam logic [4:0] ALU_SNE    = 5'd21;
    localparam logic [4:0] ALU_PASSA  = 5'd22;
    localparam logic [4:0] ALU_PASSB  = 5'd23;
    localparam logic [4:0] ALU_DIVU   = 5'd24;
    localparam logic [4:0] ALU_REM    = 5'd25;
    localparam logic [4:0] ALU_REMU   = 5'd26;
    localparam logic [4:0] ALU_DIVUW  = 5'd27;
    localparam logic [4:0] ALU_REMUW  = 5'd28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic is_multicycle(input logic [4:0] sel);
        return ((sel >= ALU_MUL) && (sel <= ALU_DIV)) ||
               ((sel >= ALU_DIVU) && (sel <= ALU_REMUW));
    endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// Combinational ALU shared by both requesters; divide-by-zero yields an
// all-ones quotient and the dividend as remainder.
module alu
    import alu_sched_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [4:0]   sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] res
);
    localparam int SW = $clog2(N);

    logic [N-1:0]        mul_lo, mulh_ss, mulh_su, mulh_uu;
    logic [N-1:0]        quot_u, rem_u, quot_s, rem_s;
    logic signed [N-1:0] sa, sb;
    logic [31:0]         a32, b32, w_res;
    logic                s_ovf;

    always_comb begin
        sa      = $signed(a);
        sb      = $signed(b);
        a32     = a[31:0];
        b32     = b[31:0];
        mul_lo  = a * b;
        mulh_ss = N'(({{N{a[N-1]}}, a} * {{N{b[N-1]}}, b}) >> N);
        mulh_su = N'(({{N{a[N-1]}}, a} * {{N{1'b0}}, b}) >> N);
        mulh_uu = N'(({{N{1'b0}}, a} * {{N{1'b0}}, b}) >> N);
        // most-negative / -1 overflows; quotient is the dividend, remainder 0
        s_ovf   = (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
        quot_u  = (b == '0) ? '1 : a / b;
        rem_u   = (b == '0) ? a  : a % b;
        quot_s  = (b == '0) ? '1 : (s_ovf ? a  : N'(sa / sb));
        rem_s   = (b == '0) ? a  : (s_ovf ? '0 : N'(sa % sb));

        w_res = '0;
        case (sel)
            ALU_ADDW:  w_res = a32 + b32;
            ALU_SUBW:  w_res = a32 - b32;
            ALU_SLLW:  w_res = a32 << b[4:0];
            ALU_SRLW:  w_res = a32 >> b[4:0];
            ALU_SRAW:  w_res = 32'($signed(a32) >>> b[4:0]);
            ALU_DIVUW: w_res = (b32 == '0) ? '1  : a32 / b32;
            ALU_REMUW: w_res = (b32 == '0) ? a32 : a32 % b32;
            default:   w_res = '0;
        endcase

        res = '0;
        case (sel)
            ALU_ADD:    res = a + b;
            ALU_SUB:    res = a - b;
            ALU_MUL:    res = mul_lo;
            ALU_MULH:   res = mulh_ss;
            ALU_MULHSU: res = mulh_su;
            ALU_MULHU:  res = mulh_uu;
            ALU_DIV:    res = quot_s;
            ALU_AND:    res = a & b;
            ALU_OR:     res = a | b;
            ALU_XOR:    res = a ^ b;
            ALU_SLL:    res = a << b[SW-1:0];
            ALU_SRL:    res = a >> b[SW-1:0];
            ALU_SRA:    res = N'(sa >>> b[SW-1:0]);
            ALU_SLT:    res = N'(sa < sb);
            ALU_SLTU:   res = N'(a < b);
            ALU_SEQ:    res = N'(a == b);
            ALU_SNE:    res = N'(a != b);
            ALU_PASSA:  res = a;
            ALU_PASSB:  res = b;
            ALU_DIVU:   res = quot_u;
            ALU_REM:    res = rem_s;
            ALU_REMU:   res = rem_u;
            ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW, ALU_DIVUW, ALU_REMUW:
                        res = N'($signed(w_res));
            default:    res = '0;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Two-requester ALU scheduler, one op in flight. Define ALU_SCHED_RR_EN for
// round-robin arbitration; otherwise requester 0 has fixed priority.
//
// state   | meaning
// IDLE    | granting a requester, operands latched on handshake
// EXEC    | counting down execute cycles of the latched op
// RESP    | result held until the consumer accepts it
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int N         = 64,
    parameter int MD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req_a0,
    input  logic [N-1:0] req_b0,
    input  logic [N-1:0] req_a1,
    input  logic [N-1:0] req_b1,
    input  logic [4:0]   req_sel0,
    input  logic [4:0]   req_sel1,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_res,
    output logic         busy
);
    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    state_t       state;
    logic [3:0]   cnt;
    logic [N-1:0] op_a, op_b, alu_res;
    logic [4:0]   op_sel, gnt_sel;
    logic         op_id, gnt_id, hs;

`ifdef ALU_SCHED_RR_EN
    logic last_grant;
    always_comb gnt_id = (&req_valid) ? ~last_grant : req_valid[1];
`else
    always_comb gnt_id = ~req_valid[0];
`endif

    always_comb begin
        req_ready = 2'b00;
        if ((state == ST_IDLE) && !rst && (|req_valid))
            req_ready = gnt_id ? 2'b10 : 2'b01;
        hs      = |req_ready;
        gnt_sel = gnt_id ? req_sel1 : req_sel0;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (hs) begin
            op_a   <= gnt_id ? req_a1 : req_a0;
            op_b   <= gnt_id ? req_b1 : req_b0;
            op_sel <= gnt_sel;
            op_id  <= gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_res   <= '0;
`ifdef ALU_SCHED_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        state <= ST_EXEC;
                        cnt   <= is_multicycle(gnt_sel) ? MD_LOAD : 4'd0;
`ifdef ALU_SCHED_RR_EN
                        last_grant <= gnt_id;
`endif
                    end
                end
                ST_EXEC: begin
                    if (cnt == 4'd0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_id    <= op_id;
                        resp_res   <= alu_res;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    alu #(.N(N)) u_alu (
        .sel (op_sel),
        .a   (op_a),
        .b   (op_b),
        .res (alu_res)
    );

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: op vectors, arbitration order, response stall
// and reset during execute. Honours ALU_SCHED_RR_EN for grant expectations.
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int N = 64;

    typedef struct {
        bit           id;
        logic [4:0]   sel;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [N-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [4:0]   req_sel0 = '0, req_sel1 = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic         resp_id;
    logic [N-1:0] resp_res;
    logic         busy;

    int checks = 0;
    int errors = 0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    alu_sched #(.N(N), .MD_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_sel0   (req_sel0),
        .req_sel1   (req_sel1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_res   (resp_res),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req_a0 = '1; req_b0 = '1; req_sel0 = 5'd2;
        req_a1 = '1; req_b1 = '1; req_sel1 = 5'd2;
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int n;
        if (v.id) begin
            req_a1 = v.a; req_b1 = v.b; req_sel1 = v.sel; req_valid = 2'b10;
        end else begin
            req_a0 = v.a; req_b0 = v.b; req_sel0 = v.sel; req_valid = 2'b01;
        end
        #1;
        check({tag, ".rdy"}, 64'(req_ready), v.id ? 64'd2 : 64'd1);
        tick();
        req_valid = 2'b00;
        scramble();
        n = 1;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(v.lat));
        check({tag, ".res"}, resp_res, v.exp);
        check({tag, ".id"}, 64'(resp_id), 64'(v.id));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n;
        logic [1:0] g[4];

        vecs[0]  = '{1'b0, ALU_ADD,   64'd5,   64'd7, 64'd12, 2};
        vecs[1]  = '{1'b1, ALU_DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5};
        vecs[2]  = '{1'b0, ALU_SUB,   64'd3,   64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 2};
        vecs[3]  = '{1'b1, ALU_MUL,   64'd6,   64'd7, 64'd42, 5};
        vecs[4]  = '{1'b0, ALU_REMU,  64'd100, 64'd0, 64'd100, 5};
        vecs[5]  = '{1'b1, ALU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5};
        vecs[6]  = '{1'b0, ALU_DIV,   64'hFFFF_FFFF_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 5};
        vecs[7]  = '{1'b0, ALU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 5};
        vecs[8]  = '{1'b1, ALU_SRA,   64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 2};
        vecs[9]  = '{1'b0, ALU_ADDW,  64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 2};
        vecs[10] = '{1'b0, 5'd30,     64'd3,   64'd4, 64'd0, 2};
        vecs[11] = '{1'b1, ALU_SLTU,  64'd1,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2};
        vecs[12] = '{1'b1, ALU_XOR,   64'hF0,  64'hFF, 64'h0F, 2};

        // reset state, with requests pending so req_ready must stay low
        req_valid = 2'b11;
        tick();
        tick();
        check("rst.ready", 64'(req_ready), 64'd0);
        check("rst.valid", 64'(resp_valid), 64'd0);
        check("rst.id", 64'(resp_id), 64'd0);
        check("rst.res", resp_res, 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++)
            run_op($sformatf("v%0d", i), vecs[i]);

        // both requesters valid every cycle, consumer always ready
        req_a0 = 64'd1; req_b0 = 64'd1; req_sel0 = ALU_ADD;
        req_a1 = 64'd2; req_b1 = 64'd2; req_sel1 = ALU_ADD;
        resp_ready = 1'b1;
        req_valid = 2'b11;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            if (req_ready != 2'b00) begin
                g[k] = req_ready;
                k++;
            end
            tick();
        end
        req_valid = 2'b00;
        check("grant.cnt", 64'(k), 64'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_SCHED_RR_EN
            check($sformatf("grant%0d", i), 64'(g[i]), (i % 2 == 1) ? 64'd2 : 64'd1);
`else
            check($sformatf("grant%0d", i), 64'(g[i]), 64'd1);
`endif
        end
        for (int c = 0; c < 20 && busy; c++)
            tick();
        resp_ready = 1'b0;
        check("grant.idle", 64'(busy), 64'd0);

        // response stall: outputs hold, no grant while waiting
        req_a0 = 64'd2; req_b0 = 64'd3; req_sel0 = ALU_ADD;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        scramble();
        n = 0;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d.valid", c), 64'(resp_valid), 64'd1);
            check($sformatf("stall%0d.res", c), resp_res, 64'd5);
            check($sformatf("stall%0d.id", c), 64'(resp_id), 64'd0);
            check($sformatf("stall%0d.ready", c), 64'(req_ready), 64'd0);
            check($sformatf("stall%0d.busy", c), 64'(busy), 64'd1);
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("release.busy", 64'(busy), 64'd0);
        check("release.valid", 64'(resp_valid), 64'd0);
        req_valid = 2'b10;
        #1;
        check("release.ready", 64'(req_ready), 64'd2);
        req_valid = 2'b00;
        tick();

        // reset while a MUL is executing discards it
        req_a0 = 64'd3; req_b0 = 64'd3; req_sel0 = ALU_MUL;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("mid.busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid.rst.valid", 64'(resp_valid), 64'd0);
        check("mid.rst.busy", 64'(busy), 64'd0);
        for (int c = 0; c < 6; c++)
            tick();
        check("mid.quiet", 64'(resp_valid), 64'd0);
        run_op("post_rst", '{1'b0, ALU_ADD, 64'd1, 64'd1, 64'd2, 2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
